// File: rtl/persiana_pkg.sv
// persiana_pkg
// Shared definitions for the multi-position blind controller:
//   - controller state encoding
//   - motor direction encoding
//   - auto_target: maps a light level onto a position index
//   - clamp_pos:   limits a requested position to the valid range
package persiana_pkg;

    typedef enum logic [2:0] {
        ST_HOMING   = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SUBIENDO = 3'd2,
        ST_BAJANDO  = 3'd3,
        ST_PAUSA    = 3'd4,
        ST_FALLA    = 3'd5
    } state_t;

    // One-hot style encoding, so the up and down outputs can never be
    // active together.
    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    // Brighter light selects a higher index, which is further down.
    // The result is floor(level * (npos-1) / (2^sens_w - 1)).
    function automatic int unsigned auto_target(input int unsigned level,
                                                input int unsigned npos,
                                                input int unsigned sens_w);
        int unsigned full_scale;
        full_scale = (32'd1 << sens_w) - 32'd1;
        return (level * (npos - 32'd1)) / full_scale;
    endfunction

    function automatic int unsigned clamp_pos(input int unsigned req,
                                              input int unsigned npos);
        return (req >= npos) ? (npos - 32'd1) : req;
    endfunction

endpackage

// File: rtl/persiana_pos_tracker.sv
// persiana_pos_tracker
// Converts the limit-sensor vector into a position index and keeps
// the last known position.
//   clk, rst   : clock and asynchronous active-high reset
//   pos_sens   : limit sensors, bit i set when the blind is at position i
//   pos_q      : registered last known position
//   pos_d      : value pos_q takes at the next edge
//   multi_hot  : two or more sensors are active together
module persiana_pos_tracker
    import persiana_pkg::*;
#(
    parameter int NPOS = 4,
    parameter int PW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NPOS-1:0] pos_sens,
    output logic [PW-1:0]   pos_q,
    output logic [PW-1:0]   pos_d,
    output logic            multi_hot
);

    logic [PW-1:0] hot_idx;

    always_comb begin
        hot_idx = '0;
        for (int i = 0; i < NPOS; i++) begin
            if (pos_sens[i]) begin
                hot_idx = PW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only when more than
    // one bit was set.
    assign multi_hot = |(pos_sens & (pos_sens - NPOS'(1)));

    // Between sensors, and while the sensor vector is inconsistent,
    // the last known position is kept.
    always_comb begin
        pos_d = pos_q;
        if ((pos_sens != '0) && !multi_hot) begin
            pos_d = hot_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

endmodule

// File: rtl/persiana_multipos.sv
// persiana_multipos
// Blind controller with NPOS limit-sensed positions. Position 0 is
// fully open (top) and NPOS-1 is fully closed (bottom). The controller
// homes upward after reset. Every stop is followed by a dead time, and
// it locks into a fault state on a motor-on timeout or on
// contradictory limit sensors.
//   Reloj, reset : clock and asynchronous active-high reset
//   cmd_valid    : one-cycle manual command strobe
//   cmd_pos      : manual target index (clamped to NPOS-1)
//   automatico   : target follows the light sensor; cmd_valid is ignored
//   sensor       : light level, higher is brighter
//   pos_sens     : limit sensors, one bit per position
//   subir/bajar  : motor up / motor down
//   en_pos       : idle and at target
//   pos_actual   : last known position
//   fault        : locked in the fault state until reset
// All outputs are flops loaded from the next-state decode. This keeps
// them equal to a decode of the current state, and it lets reset force
// them low asynchronously.
module persiana_multipos
    import persiana_pkg::*;
#(
    parameter int NPOS        = 4,
    parameter int SENS_W      = 2,
    parameter int DEAD_CYC    = 8,
    parameter int TIMEOUT_CYC = 1000,
    localparam int PW         = (NPOS > 2) ? $clog2(NPOS) : 1
) (
    input  logic              Reloj,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [PW-1:0]     cmd_pos,
    input  logic              automatico,
    input  logic [SENS_W-1:0] sensor,
    input  logic [NPOS-1:0]   pos_sens,
    output logic              subir,
    output logic              bajar,
    output logic              en_pos,
    output logic [PW-1:0]     pos_actual,
    output logic              fault
);

    localparam int OW = $clog2(TIMEOUT_CYC + 1);
    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [OW-1:0] ON_LAST   = OW'(TIMEOUT_CYC - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [PW-1:0] target_q, target_d;
    logic [OW-1:0] on_cnt_q, on_cnt_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic          en_pos_q, en_pos_d;
    logic          fault_q, fault_d;

    logic [PW-1:0] pos_q, pos_d;
    logic          multi_hot;
    logic          arrived;
    logic          timed_out;
    logic          moving;

    persiana_pos_tracker #(
        .NPOS (NPOS),
        .PW   (PW)
    ) u_tracker (
        .clk       (Reloj),
        .rst       (reset),
        .pos_sens  (pos_sens),
        .pos_q     (pos_q),
        .pos_d     (pos_d),
        .multi_hot (multi_hot)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        on_cnt_d   = on_cnt_q;
        dead_cnt_d = '0;
        arrived    = pos_sens[target_q];
        timed_out  = (on_cnt_q == ON_LAST);
        moving     = (state_q == ST_HOMING) || (state_q == ST_SUBIENDO) ||
                     (state_q == ST_BAJANDO);

        case (state_q)
            ST_HOMING: begin
                if (pos_sens[0]) begin
                    state_d = ST_PAUSA;
                end else if (timed_out) begin
                    state_d = ST_FALLA;
                end
            end
            ST_IDLE: begin
                if (target_q < pos_q) begin
                    state_d = ST_SUBIENDO;
                end else if (target_q > pos_q) begin
                    state_d = ST_BAJANDO;
                end
            end
            ST_SUBIENDO: begin
                // Between sensors pos_q is the position just left, so a
                // target equal to it already lies behind the blind.
                if (arrived || (target_q >= pos_q)) begin
                    state_d = ST_PAUSA;
                end else if (timed_out) begin
                    state_d = ST_FALLA;
                end
            end
            ST_BAJANDO: begin
                if (arrived || (target_q <= pos_q)) begin
                    state_d = ST_PAUSA;
                end else if (timed_out) begin
                    state_d = ST_FALLA;
                end
            end
            ST_PAUSA: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q + DW'(1);
                end
            end
            ST_FALLA: begin
                state_d = ST_FALLA;
            end
            default: begin
                state_d = ST_FALLA;
            end
        endcase

        // Contradictory sensors override every other transition.
        if (multi_hot && (state_q != ST_FALLA)) begin
            state_d = ST_FALLA;
        end

        if (state_d == ST_PAUSA) begin
            on_cnt_d = '0;
        end else if (moving) begin
            on_cnt_d = on_cnt_q + OW'(1);
        end

        // The auto target is sampled only while idle. This stops a
        // flickering light level from making the blind hunt mid-travel.
        if ((state_q != ST_HOMING) && (state_q != ST_FALLA)) begin
            if (automatico) begin
                if (state_q == ST_IDLE) begin
                    target_d = PW'(auto_target(32'(sensor), NPOS, SENS_W));
                end
            end else if (cmd_valid) begin
                target_d = PW'(clamp_pos(32'(cmd_pos), NPOS));
            end
        end

        case (state_d)
            ST_HOMING, ST_SUBIENDO: dir_d = DIR_UP;
            ST_BAJANDO:             dir_d = DIR_DOWN;
            default:                dir_d = DIR_STOP;
        endcase

        en_pos_d = (state_d == ST_IDLE) && (target_d == pos_d);
        fault_d  = (state_d == ST_FALLA);
    end

    always_ff @(posedge Reloj or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HOMING;
            dir_q      <= DIR_STOP;
            target_q   <= '0;
            on_cnt_q   <= '0;
            dead_cnt_q <= '0;
            en_pos_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            target_q   <= target_d;
            on_cnt_q   <= on_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            en_pos_q   <= en_pos_d;
            fault_q    <= fault_d;
        end
    end

    assign subir      = (dir_q == DIR_UP);
    assign bajar      = (dir_q == DIR_DOWN);
    assign en_pos     = en_pos_q;
    assign pos_actual = pos_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_persiana_multipos.sv
module tb_persiana_multipos;

    localparam int NPOS        = 4;
    localparam int SENS_W      = 2;
    localparam int DEAD_CYC    = 8;
    localparam int TIMEOUT_CYC = 1000;
    localparam int PW          = 2;

    // ---------------- clock / reset ----------------
    logic              Reloj = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic [PW-1:0]     cmd_pos = '0;
    logic              automatico = 1'b0;
    logic [SENS_W-1:0] sensor = '0;
    logic [NPOS-1:0]   pos_sens;
    logic              subir, bajar, en_pos, fault;
    logic [PW-1:0]     pos_actual;

    always #5 Reloj = ~Reloj;

    // ---------------- blind plant ----------------
    // Physical location in motor steps; a sensor is lit only when the
    // location is an exact multiple of step_len.
    logic            plant_en = 1'b0;
    logic [NPOS-1:0] manual_sens = '0;
    logic [NPOS-1:0] plant_sens;
    int              loc = 0;
    int              loc_init = 0;
    int              step_len = 4;

    always @(posedge Reloj) begin
        #2;
        if (!plant_en) begin
            loc = loc_init;
        end else if (subir && !bajar && loc > 0) begin
            loc = loc - 1;
        end else if (bajar && !subir && loc < (NPOS - 1) * step_len) begin
            loc = loc + 1;
        end
    end

    assign plant_sens = ((loc % step_len) == 0) ? (NPOS'(1) << (loc / step_len)) : '0;
    assign pos_sens   = plant_en ? plant_sens : manual_sens;

    persiana_multipos #(
        .NPOS(NPOS), .SENS_W(SENS_W), .DEAD_CYC(DEAD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .Reloj(Reloj), .reset(reset), .cmd_valid(cmd_valid), .cmd_pos(cmd_pos),
        .automatico(automatico), .sensor(sensor), .pos_sens(pos_sens),
        .subir(subir), .bajar(bajar), .en_pos(en_pos),
        .pos_actual(pos_actual), .fault(fault)
    );

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [PW-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns one negedge later with the strobe low.
    task automatic pulse_cmd(input int p);
        cmd_pos   = PW'(p);
        cmd_valid = 1'b1;
        @(negedge Reloj);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_en_pos(input int budget, output int waited);
        waited = 0;
        while (waited < budget) begin
            @(negedge Reloj);
            waited++;
            if (en_pos === 1'b1) break;
        end
    endtask

    // Reset with the blind already resting on the top sensor.
    task automatic home_manual(output int subir_cnt, output int waited);
        plant_en    = 1'b0;
        manual_sens = 4'b0001;
        cmd_valid   = 1'b0;
        automatico  = 1'b0;
        reset       = 1'b1;
        repeat (2) @(negedge Reloj);
        reset     = 1'b0;
        subir_cnt = 0;
        waited    = 0;
        while (waited < 60) begin
            @(negedge Reloj);
            waited++;
            if (subir === 1'b1) subir_cnt++;
            if (en_pos === 1'b1) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        plant_en    = 1'b0;
        manual_sens = '0;
        reset       = 1'b1;
        repeat (2) @(negedge Reloj);
        n_checks++; if (subir !== 1'b0) $display("FAIL reset_subir: got %b want 0", subir); else n_pass++;
        n_checks++; if (bajar !== 1'b0) $display("FAIL reset_bajar: got %b want 0", bajar); else n_pass++;
        n_checks++; if (en_pos !== 1'b0) $display("FAIL reset_en_pos: got %b want 0", en_pos); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else n_pass++;
        n_checks++; if (pos_actual !== 2'd0) $display("FAIL reset_pos: got %0d want 0", pos_actual); else n_pass++;
    endtask

    task automatic test_homing();
        int up_cnt, quiet_cnt;
        up_cnt = 0;
        quiet_cnt = 0;
        reset = 1'b0;
        repeat (20) begin
            @(negedge Reloj);
            if (subir === 1'b1 && bajar === 1'b0) up_cnt++;
        end
        manual_sens = 4'b0001;
        repeat (DEAD_CYC) begin
            @(negedge Reloj);
            if (subir === 1'b0 && bajar === 1'b0 && en_pos === 1'b0) quiet_cnt++;
        end
        @(negedge Reloj);
        n_checks++; if (up_cnt !== 20) $display("FAIL homing_subir_cycles: got %0d want 20", up_cnt); else n_pass++;
        n_checks++; if (quiet_cnt !== DEAD_CYC) $display("FAIL homing_pause: got %0d want %0d", quiet_cnt, DEAD_CYC); else n_pass++;
        n_checks++; if (en_pos !== 1'b1) $display("FAIL homing_en_pos: got %b want 1", en_pos); else n_pass++;
        n_checks++; if (pos_actual !== 2'd0) $display("FAIL homing_pos: got %0d want 0", pos_actual); else n_pass++;
    endtask

    task automatic test_manual_down();
        logic [NPOS-1:0] seq [5];
        int bad, waited;
        seq = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
        bad = 0;
        pulse_cmd(3);
        n_checks++; if (en_pos !== 1'b0) $display("FAIL down_en_pos_drop: got %b want 0", en_pos); else n_pass++;
        @(negedge Reloj);
        for (int i = 0; i < 5; i++) begin
            manual_sens = seq[i];
            repeat (2) begin
                if (bajar !== 1'b1 || subir !== 1'b0) bad++;
                @(negedge Reloj);
            end
        end
        manual_sens = 4'b1000;
        if (bajar !== 1'b1 || subir !== 1'b0) bad++;
        @(negedge Reloj);
        n_checks++; if (bad !== 0) $display("FAIL down_motion: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (bajar !== 1'b0) $display("FAIL down_stop: got %b want 0", bajar); else n_pass++;
        n_checks++; if (pos_actual !== 2'd3) $display("FAIL down_pos: got %0d want 3", pos_actual); else n_pass++;
        wait_en_pos(40, waited);
        n_checks++; if (waited !== DEAD_CYC) $display("FAIL down_dead_time: got %0d want %0d", waited, DEAD_CYC); else n_pass++;
    endtask

    task automatic test_reversal();
        int up0, waited, gap, overlap;
        bit seen_up;
        home_manual(up0, waited);
        n_checks++; if (up0 > 1) $display("FAIL rehome_subir: got %0d want <=1", up0); else n_pass++;
        n_checks++; if (waited !== DEAD_CYC + 1) $display("FAIL rehome_latency: got %0d want %0d", waited, DEAD_CYC + 1); else n_pass++;
        pulse_cmd(3);
        manual_sens = 4'b0000;
        repeat (2) @(negedge Reloj);
        manual_sens = 4'b0010;
        repeat (2) @(negedge Reloj);
        n_checks++; if (pos_actual !== 2'd1) $display("FAIL rev_at_pos1: got %0d want 1", pos_actual); else n_pass++;
        pulse_cmd(0);
        n_checks++; if (bajar !== 1'b1) $display("FAIL rev_still_down: got %b want 1", bajar); else n_pass++;
        gap = 0;
        overlap = 0;
        seen_up = 1'b0;
        for (int i = 0; i < 40 && !seen_up; i++) begin
            @(negedge Reloj);
            if (subir === 1'b1 && bajar === 1'b1) overlap++;
            if (subir === 1'b1) seen_up = 1'b1;
            else if (bajar === 1'b0) gap++;
        end
        n_checks++; if (!seen_up || gap !== DEAD_CYC + 1) $display("FAIL rev_gap: got %0d (up=%b) want %0d", gap, seen_up, DEAD_CYC + 1); else n_pass++;
        n_checks++; if (overlap !== 0) $display("FAIL rev_overlap: got %0d want 0", overlap); else n_pass++;
        manual_sens = 4'b0000;
        repeat (2) @(negedge Reloj);
        manual_sens = 4'b0001;
        wait_en_pos(40, waited);
        n_checks++; if (en_pos !== 1'b1 || pos_actual !== 2'd0) $display("FAIL rev_home: got en=%b pos=%0d want en=1 pos=0", en_pos, pos_actual); else n_pass++;
    endtask

    task automatic test_auto();
        int exp_t, waited, bad;
        logic [NPOS-1:0] seq [3];
        seq = '{4'b0000, 4'b0010, 4'b0000};
        exp_t = (2 * (NPOS - 1)) / ((1 << SENS_W) - 1);
        bad = 0;
        automatico = 1'b1;
        sensor     = 2'd2;
        pulse_cmd(3);
        @(negedge Reloj);
        n_checks++; if (bajar !== 1'b1) $display("FAIL auto_start: got %b want 1", bajar); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            manual_sens = seq[i];
            repeat (2) begin
                @(negedge Reloj);
                if (bajar !== 1'b1) bad++;
            end
        end
        manual_sens = 4'b0100;
        @(negedge Reloj);
        n_checks++; if (bad !== 0 || bajar !== 1'b0) $display("FAIL auto_stop: got bad=%0d bajar=%b want 0,0", bad, bajar); else n_pass++;
        wait_en_pos(40, waited);
        n_checks++; if (pos_actual !== PW'(exp_t) || en_pos !== 1'b1) $display("FAIL auto_pos: got %0d en=%b want %0d en=1", pos_actual, en_pos, exp_t); else n_pass++;
        pulse_cmd(0);
        bad = 0;
        repeat (12) begin
            @(negedge Reloj);
            if (subir !== 1'b0 || bajar !== 1'b0 || en_pos !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL auto_ignores_cmd: got %0d bad cycles want 0", bad); else n_pass++;
        automatico = 1'b0;
    endtask

    task automatic test_timeout();
        int up0, waited, on_cnt, bad;
        bit hit;
        home_manual(up0, waited);
        pulse_cmd(3);
        manual_sens = 4'b0000;
        on_cnt = 0;
        hit = 1'b0;
        for (int i = 0; i < 1200 && !hit; i++) begin
            @(negedge Reloj);
            if (bajar === 1'b1) on_cnt++;
            if (fault === 1'b1) hit = 1'b1;
        end
        n_checks++; if (!hit || on_cnt !== TIMEOUT_CYC) $display("FAIL timeout_cycles: got %0d (fault=%b) want %0d", on_cnt, hit, TIMEOUT_CYC); else n_pass++;
        n_checks++; if (subir !== 1'b0 || bajar !== 1'b0) $display("FAIL timeout_outputs: got %b%b want 00", subir, bajar); else n_pass++;
        manual_sens = 4'b0001;
        pulse_cmd(0);
        bad = 0;
        repeat (20) begin
            @(negedge Reloj);
            if (fault !== 1'b1 || subir !== 1'b0 || bajar !== 1'b0 || en_pos !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL timeout_held: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_sensor_fault();
        int up0, waited;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (fault !== 1'b0) $display("FAIL fault_async_clear: got %b want 0", fault); else n_pass++;
        home_manual(up0, waited);
        manual_sens = 4'b0110;
        @(negedge Reloj);
        n_checks++; if (fault !== 1'b1 || en_pos !== 1'b0) $display("FAIL multi_hot: got fault=%b en=%b want 1,0", fault, en_pos); else n_pass++;
        home_manual(up0, waited);
        pulse_cmd(3);
        manual_sens = 4'b0000;
        repeat (5) @(negedge Reloj);
        n_checks++; if (bajar !== 1'b1) $display("FAIL midmove_running: got %b want 1", bajar); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bajar !== 1'b0 || fault !== 1'b0 || pos_actual !== 2'd0) $display("FAIL midmove_reset: got bajar=%b fault=%b pos=%0d want 0,0,0", bajar, fault, pos_actual); else n_pass++;
        @(negedge Reloj);
        reset = 1'b0;
        @(negedge Reloj);
        n_checks++; if (subir !== 1'b1) $display("FAIL rehoming: got %b want 1", subir); else n_pass++;
        manual_sens = 4'b0001;
        wait_en_pos(40, waited);
        n_checks++; if (en_pos !== 1'b1) $display("FAIL rehome_done: got %b want 1", en_pos); else n_pass++;
    endtask

    task automatic test_random_moves();
        int cur, t, s, k, waited, up_cnt, dn_cnt, both_cnt, exp_lat;
        bit use_auto;
        logic [PW-1:0] exp_pos;
        step_len = $urandom_range(3, 6);
        loc_init = $urandom_range(0, (NPOS - 1) * step_len);
        cmd_valid  = 1'b0;
        automatico = 1'b0;
        reset      = 1'b1;
        repeat (2) @(negedge Reloj);
        plant_en = 1'b1;
        @(negedge Reloj);
        reset = 1'b0;
        wait_en_pos(200, waited);
        n_checks++; if (en_pos !== 1'b1 || pos_actual !== 2'd0) $display("FAIL plant_home: got en=%b pos=%0d want 1,0", en_pos, pos_actual); else n_pass++;
        cur = 0;
        for (int it = 0; it < 10; it++) begin
            use_auto = ($urandom_range(0, 3) == 0);
            if (use_auto) begin
                s = $urandom_range(0, (1 << SENS_W) - 1);
                t = (s * (NPOS - 1)) / ((1 << SENS_W) - 1);
            end else begin
                t = $urandom_range(0, NPOS - 1);
            end
            exp_q.push_back(PW'(t));
            k = ((t > cur) ? (t - cur) : (cur - t)) * step_len;
            exp_lat = (k == 0) ? 1 : k + DEAD_CYC + 2;
            if (use_auto) begin
                automatico = 1'b1;
                sensor = SENS_W'(s);
            end else begin
                cmd_pos = PW'(t);
                cmd_valid = 1'b1;
            end
            up_cnt = 0;
            dn_cnt = 0;
            both_cnt = 0;
            waited = 0;
            while (waited < 100) begin
                @(negedge Reloj);
                cmd_valid = 1'b0;
                waited++;
                if (subir === 1'b1 && bajar === 1'b1) both_cnt++;
                else if (subir === 1'b1) up_cnt++;
                else if (bajar === 1'b1) dn_cnt++;
                if (en_pos === 1'b1) break;
            end
            automatico = 1'b0;
            exp_pos = exp_q.pop_front();
            n_checks++; if (pos_actual !== exp_pos) $display("FAIL rand_pos[%0d]: got %0d want %0d", it, pos_actual, exp_pos); else n_pass++;
            n_checks++; if (waited !== exp_lat) $display("FAIL rand_latency[%0d]: got %0d want %0d", it, waited, exp_lat); else n_pass++;
            n_checks++; if (up_cnt !== ((t < cur) ? k : 0) || dn_cnt !== ((t > cur) ? k : 0) || both_cnt !== 0)
                $display("FAIL rand_motor[%0d]: got up=%0d dn=%0d both=%0d want up=%0d dn=%0d both=0",
                         it, up_cnt, dn_cnt, both_cnt, (t < cur) ? k : 0, (t > cur) ? k : 0);
            else n_pass++;
            cur = t;
        end
        plant_en = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_homing();
        test_manual_down();
        test_reversal();
        test_auto();
        test_timeout();
        test_sensor_fault();
        test_random_moves();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
